// File: rtl/imem_arb_pkg.sv
// ---------------------------------------------------------------------------
// imem_arb_pkg : shared types for the instruction-RAM port arbiter. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package imem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LD   = 2'd2
  } owner_e;

endpackage : imem_arb_pkg

`default_nettype wire

// File: rtl/imem_port_arbiter.sv
// ---------------------------------------------------------------------------
// imem_port_arbiter : shares one instruction-RAM port between fetch and loader.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module imem_port_arbiter
  import imem_arb_pkg::*;
#(
  parameter int IMEM_ADDR_WIDTH = 12,
  parameter int MAX_WAIT        = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,

  input  logic                       i_if_req,
  input  logic [IMEM_ADDR_WIDTH-1:0] i_if_addr,
  output logic                       o_if_gnt,
  output logic                       o_if_rvalid,
  output logic [31:0]                o_if_rdata,

  input  logic                       i_ld_req,
  input  logic                       i_ld_we,
  input  logic [3:0]                 i_ld_be,
  input  logic [IMEM_ADDR_WIDTH-1:0] i_ld_addr,
  input  logic [31:0]                i_ld_wdata,
  output logic                       o_ld_gnt,
  output logic                       o_ld_rvalid,
  output logic [31:0]                o_ld_rdata,

  output logic [IMEM_ADDR_WIDTH-1:0] o_ram_addr,
  output logic                       o_ram_we,
  output logic [3:0]                 o_ram_size,
  output logic [31:0]                o_ram_din,
  input  logic [31:0]                i_ram_dout
);

  localparam int                      WCNT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [WCNT_W-1:0]       WAIT_SAT = WCNT_W'(MAX_WAIT);

  logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
  owner_e            owner_q,    owner_d;

  logic              fetch_prio;
  logic              if_gnt;
  logic              ld_gnt;
  logic              unused_addr_lsbs;

  // Word-aligned RAM port: the byte offset bits of both requesters are don't-care.
  assign unused_addr_lsbs = ^{i_if_addr[1:0], i_ld_addr[1:0]};

  // Grants are forced low while reset is held so the RAM sees no activity.
  always_comb begin
    fetch_prio = (wait_cnt_q == WAIT_SAT);
    if_gnt     = i_rst_n && i_if_req && (!i_ld_req || fetch_prio);
    ld_gnt     = i_rst_n && i_ld_req && !if_gnt;
  end

  assign o_if_gnt = if_gnt;
  assign o_ld_gnt = ld_gnt;

  always_comb begin
    o_ram_addr = '0;
    o_ram_we   = 1'b0;
    o_ram_size = 4'b0000;
    o_ram_din  = '0;
    if (if_gnt) begin
      o_ram_addr = {i_if_addr[IMEM_ADDR_WIDTH-1:2], 2'b00};
    end else if (ld_gnt) begin
      o_ram_addr = {i_ld_addr[IMEM_ADDR_WIDTH-1:2], 2'b00};
      o_ram_we   = i_ld_we;
      o_ram_size = i_ld_we ? i_ld_be : 4'b0000;
      o_ram_din  = i_ld_wdata;
    end
  end

  always_comb begin
    wait_cnt_d = '0;
    if (i_if_req && !if_gnt) begin
      wait_cnt_d = (wait_cnt_q == WAIT_SAT) ? wait_cnt_q : wait_cnt_q + 1'b1;
    end
  end

  // The owner remembers who gets next cycle's registered RAM output.
  always_comb begin
    owner_d = OWN_NONE;
    if (if_gnt) begin
      owner_d = OWN_IF;
    end else if (ld_gnt && !i_ld_we) begin
      owner_d = OWN_LD;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wait_cnt_q <= '0;
      owner_q    <= OWN_NONE;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      owner_q    <= owner_d;
    end
  end

  always_comb begin
    o_if_rvalid = (owner_q == OWN_IF);
    o_ld_rvalid = (owner_q == OWN_LD);
    o_if_rdata  = o_if_rvalid ? i_ram_dout : 32'h0;
    o_ld_rdata  = o_ld_rvalid ? i_ram_dout : 32'h0;
  end

endmodule : imem_port_arbiter

`default_nettype wire

// File: tb/tb_imem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_imem_port_arbiter : directed vectors plus randomized traffic vs. a model.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_imem_port_arbiter;

  localparam int AW       = 12;
  localparam int MAX_WAIT = 4;
  localparam int WORDS    = 1 << (AW - 2);

  logic          clk;
  logic          rst_n;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt, if_rvalid;
  logic [31:0]   if_rdata;
  logic          ld_req, ld_we;
  logic [3:0]    ld_be;
  logic [AW-1:0] ld_addr;
  logic [31:0]   ld_wdata;
  logic          ld_gnt, ld_rvalid;
  logic [31:0]   ld_rdata;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [3:0]    ram_size;
  logic [31:0]   ram_din;
  logic [31:0]   ram_dout;

  imem_port_arbiter #(.IMEM_ADDR_WIDTH(AW), .MAX_WAIT(MAX_WAIT)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_if_req   (if_req),
    .i_if_addr  (if_addr),
    .o_if_gnt   (if_gnt),
    .o_if_rvalid(if_rvalid),
    .o_if_rdata (if_rdata),
    .i_ld_req   (ld_req),
    .i_ld_we    (ld_we),
    .i_ld_be    (ld_be),
    .i_ld_addr  (ld_addr),
    .i_ld_wdata (ld_wdata),
    .o_ld_gnt   (ld_gnt),
    .o_ld_rvalid(ld_rvalid),
    .o_ld_rdata (ld_rdata),
    .o_ram_addr (ram_addr),
    .o_ram_we   (ram_we),
    .o_ram_size (ram_size),
    .o_ram_din  (ram_din),
    .i_ram_dout (ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction RAM stand-in: byte-lane writes, one-cycle registered read.
  logic [31:0] ram [0:WORDS-1];
  always @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (ram_size[b]) ram[ram_addr[AW-1:2]][8*b +: 8] <= ram_din[8*b +: 8];
      end
    end
    ram_dout <= ram[ram_addr[AW-1:2]];
  end

  // Reference model state: expected memory image, starvation count, pending responses.
  typedef struct {
    bit to_if;
    int word;
  } rsp_t;

  logic [31:0] exp_mem [0:WORDS-1];
  int          starve;
  rsp_t        rsp_q[$];

  int n_tests;
  int n_fail;
  int cyc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d: got %h, expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic drive(input logic rv, input logic ifr, input logic [AW-1:0] ifa,
                       input logic ldr, input logic ldw, input logic [3:0] be,
                       input logic [AW-1:0] lda, input logic [31:0] wd);
    rst_n    = rv;
    if_req   = ifr;
    if_addr  = ifa;
    ld_req   = ldr;
    ld_we    = ldw;
    ld_be    = be;
    ld_addr  = lda;
    ld_wdata = wd;
    #4;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic model_check();
    logic        e_ifg, e_ldg, e_we, e_ifv, e_ldv;
    logic [3:0]  e_sz;
    logic [AW-1:0] e_ad;
    logic [31:0] e_din, e_dat;
    int          w;
    rsp_t        r;
    e_ifg = 0; e_ldg = 0; e_we = 0; e_ifv = 0; e_ldv = 0;
    e_sz = 0; e_ad = 0; e_din = 0; e_dat = 0;
    if (!rst_n) begin
      rsp_q.delete();
      starve = 0;
    end else begin
      if (rsp_q.size() > 0) begin
        r = rsp_q.pop_front();
        if (r.to_if) e_ifv = 1; else e_ldv = 1;
        e_dat = exp_mem[r.word];
      end
      e_ifg = if_req && (!ld_req || starve >= MAX_WAIT);
      e_ldg = ld_req && !e_ifg;
      if (e_ifg) begin
        w    = int'(if_addr) / 4;
        e_ad = AW'(w * 4);
        rsp_q.push_back('{1'b1, w});
      end else if (e_ldg) begin
        w     = int'(ld_addr) / 4;
        e_ad  = AW'(w * 4);
        e_din = ld_wdata;
        if (ld_we) begin
          e_we = 1;
          e_sz = ld_be;
          for (int b = 0; b < 4; b++) begin
            if (ld_be[b]) exp_mem[w][8*b +: 8] = ld_wdata[8*b +: 8];
          end
        end else begin
          rsp_q.push_back('{1'b0, w});
        end
      end
      if (if_req && !e_ifg) starve = (starve < MAX_WAIT) ? starve + 1 : MAX_WAIT;
      else                  starve = 0;
    end
    chk("m_if_gnt",    if_gnt,    e_ifg);
    chk("m_ld_gnt",    ld_gnt,    e_ldg);
    chk("m_ram_we",    ram_we,    e_we);
    chk("m_ram_size",  ram_size,  e_sz);
    chk("m_ram_addr",  ram_addr,  e_ad);
    chk("m_ram_din",   ram_din,   e_din);
    chk("m_if_rvalid", if_rvalid, e_ifv);
    chk("m_ld_rvalid", ld_rvalid, e_ldv);
    chk("m_if_rdata",  if_rdata,  e_ifv ? e_dat : 32'h0);
    chk("m_ld_rdata",  ld_rdata,  e_ldv ? e_dat : 32'h0);
  endtask

  typedef struct {
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          ld_req;
    logic          ld_we;
    logic [3:0]    ld_be;
    logic [AW-1:0] ld_addr;
    logic [31:0]   ld_wdata;
    logic          e_if_gnt;
    logic          e_ld_gnt;
    logic          e_we;
    logic [3:0]    e_size;
    logic [AW-1:0] e_addr;
    logic [31:0]   e_din;
    logic          e_if_rv;
    logic          e_ld_rv;
    logic [31:0]   e_rdata;
  } vec_t;

  vec_t vecs [0:15];

  initial begin
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    starve  = 0;
    ram_dout = 32'h0;
    for (int i = 0; i < WORDS; i++) begin
      ram[i]     = 32'h0;
      exp_mem[i] = 32'h0;
    end
    ram[12'h010 >> 2] = 32'hDEADBEEF; exp_mem[12'h010 >> 2] = 32'hDEADBEEF;
    ram[12'h020 >> 2] = 32'h12345678; exp_mem[12'h020 >> 2] = 32'h12345678;

    //          ifr if_addr  ldr we  be     ld_addr  wdata          ifg ldg we size  addr     din            ifv ldv rdata
    vecs[0]  = '{1, 12'h010, 0, 0, 4'h0, 12'h000, 32'h0,          1, 0, 0, 4'h0, 12'h010, 32'h0,          0, 0, 32'h0};
    vecs[1]  = '{0, 12'h000, 0, 0, 4'h0, 12'h000, 32'h0,          0, 0, 0, 4'h0, 12'h000, 32'h0,          1, 0, 32'hDEADBEEF};
    vecs[2]  = '{0, 12'h000, 1, 1, 4'h8, 12'h013, 32'h0A000000,   0, 1, 1, 4'h8, 12'h010, 32'h0A000000,   0, 0, 32'h0};
    vecs[3]  = '{0, 12'h000, 1, 0, 4'hF, 12'h010, 32'h0,          0, 1, 0, 4'h0, 12'h010, 32'h0,          0, 0, 32'h0};
    vecs[4]  = '{0, 12'h000, 0, 0, 4'h0, 12'h000, 32'h0,          0, 0, 0, 4'h0, 12'h000, 32'h0,          0, 1, 32'h0AADBEEF};
    vecs[5]  = '{1, 12'h011, 0, 0, 4'h0, 12'h000, 32'h0,          1, 0, 0, 4'h0, 12'h010, 32'h0,          0, 0, 32'h0};
    vecs[6]  = '{0, 12'h000, 1, 0, 4'h0, 12'h020, 32'h0,          0, 1, 0, 4'h0, 12'h020, 32'h0,          1, 0, 32'h0AADBEEF};
    vecs[7]  = '{1, 12'h010, 0, 0, 4'h0, 12'h000, 32'h0,          1, 0, 0, 4'h0, 12'h010, 32'h0,          0, 1, 32'h12345678};
    vecs[8]  = '{0, 12'h000, 0, 0, 4'h0, 12'h000, 32'h0,          0, 0, 0, 4'h0, 12'h000, 32'h0,          1, 0, 32'h0AADBEEF};
    vecs[9]  = '{0, 12'h000, 1, 1, 4'h0, 12'h020, 32'hFFFFFFFF,   0, 1, 1, 4'h0, 12'h020, 32'hFFFFFFFF,   0, 0, 32'h0};
    vecs[10] = '{0, 12'h000, 1, 0, 4'h0, 12'h022, 32'h0,          0, 1, 0, 4'h0, 12'h020, 32'h0,          0, 0, 32'h0};
    vecs[11] = '{0, 12'h000, 0, 0, 4'h0, 12'h000, 32'h0,          0, 0, 0, 4'h0, 12'h000, 32'h0,          0, 1, 32'h12345678};
    vecs[12] = '{0, 12'h000, 1, 1, 4'h1, 12'h020, 32'h000000AB,   0, 1, 1, 4'h1, 12'h020, 32'h000000AB,   0, 0, 32'h0};
    vecs[13] = '{1, 12'h010, 1, 0, 4'h0, 12'h020, 32'h0,          0, 1, 0, 4'h0, 12'h020, 32'h0,          0, 0, 32'h0};
    vecs[14] = '{1, 12'h010, 0, 0, 4'h0, 12'h000, 32'h0,          1, 0, 0, 4'h0, 12'h010, 32'h0,          0, 1, 32'h123456AB};
    vecs[15] = '{0, 12'h000, 0, 0, 4'h0, 12'h000, 32'h0,          0, 0, 0, 4'h0, 12'h000, 32'h0,          1, 0, 32'h0AADBEEF};

    @(posedge clk);
    #1;

    // Reset held with both requesters active: everything must read zero.
    for (int k = 0; k < 2; k++) begin
      drive(0, 1, 12'h010, 1, 1, 4'hF, 12'h020, 32'hFFFFFFFF);
      chk("rst_if_gnt",    if_gnt,    1'b0);
      chk("rst_ld_gnt",    ld_gnt,    1'b0);
      chk("rst_ram_we",    ram_we,    1'b0);
      chk("rst_ram_size",  ram_size,  4'h0);
      chk("rst_rvalid",    {if_rvalid, ld_rvalid}, 2'b00);
      chk("rst_rdata_or",  if_rdata | ld_rdata, 32'h0);
      model_check();
      tick();
    end
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    model_check();
    tick();

    for (int i = 0; i < 16; i++) begin
      drive(1, vecs[i].if_req, vecs[i].if_addr, vecs[i].ld_req, vecs[i].ld_we,
            vecs[i].ld_be, vecs[i].ld_addr, vecs[i].ld_wdata);
      chk($sformatf("vec%0d_if_gnt", i),    if_gnt,    vecs[i].e_if_gnt);
      chk($sformatf("vec%0d_ld_gnt", i),    ld_gnt,    vecs[i].e_ld_gnt);
      chk($sformatf("vec%0d_ram_we", i),    ram_we,    vecs[i].e_we);
      chk($sformatf("vec%0d_ram_size", i),  ram_size,  vecs[i].e_size);
      chk($sformatf("vec%0d_ram_addr", i),  ram_addr,  vecs[i].e_addr);
      chk($sformatf("vec%0d_ram_din", i),   ram_din,   vecs[i].e_din);
      chk($sformatf("vec%0d_if_rvalid", i), if_rvalid, vecs[i].e_if_rv);
      chk($sformatf("vec%0d_ld_rvalid", i), ld_rvalid, vecs[i].e_ld_rv);
      chk($sformatf("vec%0d_if_rdata", i),  if_rdata,  vecs[i].e_if_rv ? vecs[i].e_rdata : 32'h0);
      chk($sformatf("vec%0d_ld_rdata", i),  ld_rdata,  vecs[i].e_ld_rv ? vecs[i].e_rdata : 32'h0);
      model_check();
      tick();
    end

    // Starvation: both request every cycle; fetch wins every (MAX_WAIT+1)th cycle.
    for (int k = 0; k < 3 * (MAX_WAIT + 1); k++) begin
      drive(1, 1, 12'h020, 1, 0, 4'h0, 12'h010, 32'h0);
      chk("starve_if_gnt", if_gnt, (k % (MAX_WAIT + 1)) == MAX_WAIT);
      chk("starve_ld_gnt", ld_gnt, (k % (MAX_WAIT + 1)) != MAX_WAIT);
      model_check();
      tick();
    end
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    model_check();
    tick();

    // Reset pulsed the cycle after a fetch grant drops the pending response.
    drive(1, 1, 12'h010, 0, 0, 0, 0, 0);
    chk("rmid_if_gnt", if_gnt, 1'b1);
    model_check();
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("rmid_if_rvalid_low", if_rvalid, 1'b0);
    model_check();
    tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    chk("rmid_no_late_rvalid", if_rvalid, 1'b0);
    model_check();
    tick();
    drive(1, 1, 12'h020, 0, 0, 0, 0, 0);
    chk("rmid_regrant", if_gnt, 1'b1);
    model_check();
    tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    chk("rmid_rvalid", if_rvalid, 1'b1);
    chk("rmid_rdata",  if_rdata,  32'h123456AB);
    model_check();
    tick();

    // Randomized traffic over a small address window to force reuse and hazards.
    for (int k = 0; k < 400; k++) begin
      drive(($urandom_range(0, 39) != 0),
            1'($urandom_range(0, 1)), AW'($urandom_range(0, 63)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            AW'($urandom_range(0, 63)), $urandom);
      model_check();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_imem_port_arbiter

`default_nettype wire
